// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared constants for the multicycle MIPS control unit:
//   - 4-bit state codes (also exported on the debug `state` port)
//   - supported opcode values (IR[31:26])
//   - ALU-op, ALU-src-B and PC-source mux encodings
//   - ctrl_t: the bundle of every control output, so the top can build it
//     once and gate it with reset in a single place
// -----------------------------------------------------------------------------
package mips_pkg;

    // State codes. FETCH is 0, so a gated-off state output still reads FETCH.
    localparam logic [3:0] ST_FETCH     = 4'd0;
    localparam logic [3:0] ST_DECODE    = 4'd1;
    localparam logic [3:0] ST_MEM_ADDR  = 4'd2;
    localparam logic [3:0] ST_MEM_READ  = 4'd3;
    localparam logic [3:0] ST_MEM_WB    = 4'd4;
    localparam logic [3:0] ST_MEM_WRITE = 4'd5;
    localparam logic [3:0] ST_R_EXEC    = 4'd6;
    localparam logic [3:0] ST_R_WB      = 4'd7;
    localparam logic [3:0] ST_I_EXEC    = 4'd8;
    localparam logic [3:0] ST_I_WB      = 4'd9;
    localparam logic [3:0] ST_BRANCH    = 4'd10;
    localparam logic [3:0] ST_JUMP      = 4'd11;
    localparam logic [3:0] ST_ILLEGAL   = 4'd12;

    // Opcodes (IR[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    // ALU operation select.
    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    // ALU source-B select.
    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    // PC source select.
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef struct packed {
        logic       pc_en;
        logic       ir_en;
        logic       mdr_en;
        logic       ab_en;
        logic       aluout_en;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal;
        logic       mem_err;
    } ctrl_t;

    // States that wait on mem_ready and therefore run the timeout counter.
    function automatic logic is_mem_state(input logic [3:0] s);
        return (s == ST_FETCH) || (s == ST_MEM_READ) || (s == ST_MEM_WRITE);
    endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// -----------------------------------------------------------------------------
// mips_mc_ctrl_if
// Control bus between the multicycle control FSM and the datapath.
//   datapath -> ctrl : opcode, zero, mem_ready
//   ctrl -> datapath : register enables, mux selects, memory strobes,
//                      status pulses (instr_done, illegal, mem_err), state
// modport master : the control FSM
// modport slave  : the datapath / memory side
// -----------------------------------------------------------------------------
interface mips_mc_ctrl_if;

    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       pc_en;
    logic       ir_en;
    logic       mdr_en;
    logic       ab_en;
    logic       aluout_en;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal;
    logic       mem_err;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_en, ir_en, mdr_en, ab_en, aluout_en, reg_write,
               mem_read, mem_write, iord, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_op, pc_source,
               instr_done, illegal, mem_err, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_en, ir_en, mdr_en, ab_en, aluout_en, reg_write,
               mem_read, mem_write, iord, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_op, pc_source,
               instr_done, illegal, mem_err, state
    );

endinterface

// File: rtl/mips_mem_wait.sv
// -----------------------------------------------------------------------------
// mips_mem_wait
// Memory wait-state counter with timeout compare.
//   clk, rst_n : clock, async active-low reset
//   clr        : owning FSM is changing state this cycle
//   busy       : FSM is in a state that waits on memory
//   ready      : memory completes the access this cycle
//   expired    : ready is low and MEM_WAIT_MAX wait cycles have already elapsed
// The count tracks consecutive low-ready cycles inside one memory state.
// -----------------------------------------------------------------------------
module mips_mem_wait #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic busy,
    input  logic ready,
    output logic expired
);

    localparam int             CW    = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CW-1:0]  LIMIT = CW'(MEM_WAIT_MAX);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // ready on the limit cycle wins: expired needs ready low.
    assign expired = busy && !ready && (cnt_q == LIMIT);

    always_comb begin
        // NOTE: default assignment first so every path drives cnt_d; no latch.
        cnt_d = cnt_q;
        // A timeout in FETCH loops back to FETCH without a state change,
        // so expiry clears the count on its own.
        if (clr || !busy || ready || expired) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// -----------------------------------------------------------------------------
// mips_mc_ctrl
// Multicycle MIPS control FSM. Steps one instruction through fetch, decode,
// execute, memory and writeback, and is the only source of the datapath
// register enables, mux selects and memory strobes.
//   clk : rising-edge clock
//   rst : async active-low reset; also forces every output to 0 while low
//   bus : mips_mc_ctrl_if.master (opcode/zero/mem_ready in, controls out)
// Outputs decode from the current state; pc_en/ir_en/mdr_en and the memory
// completion pulses are additionally qualified by mem_ready and zero.
// -----------------------------------------------------------------------------
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    mips_mc_ctrl_if.master   bus
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    ctrl_t      ctrl_d;
    ctrl_t      ctrl_out;
    logic       expired;
    logic       wait_clr;

    assign wait_clr = (state_d != state_q);

    mips_mem_wait #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_wait (
        .clk     (clk),
        .rst_n   (rst),
        .clr     (wait_clr),
        .busy    (is_mem_state(state_q)),
        .ready   (bus.mem_ready),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        ctrl_d  = '0;
        case (state_q)
            ST_FETCH: begin
                ctrl_d.mem_read  = 1'b1;
                ctrl_d.alu_src_b = SRCB_FOUR;
                if (bus.mem_ready) begin
                    ctrl_d.ir_en = 1'b1;
                    ctrl_d.pc_en = 1'b1;
                    state_d      = ST_DECODE;
                end else if (expired) begin
                    ctrl_d.mem_err = 1'b1;
                end
            end
            ST_DECODE: begin
                ctrl_d.ab_en     = 1'b1;
                ctrl_d.aluout_en = 1'b1;
                ctrl_d.alu_src_b = SRCB_IMM_SH;
                case (bus.opcode)
                    OP_RTYPE:     state_d = ST_R_EXEC;
                    OP_LW, OP_SW: state_d = ST_MEM_ADDR;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    OP_ADDI:      state_d = ST_I_EXEC;
                    default:      state_d = ST_ILLEGAL;
                endcase
            end
            ST_R_EXEC: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_op    = ALU_FUNCT;
                ctrl_d.aluout_en = 1'b1;
                state_d          = ST_R_WB;
            end
            ST_R_WB: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.reg_dst    = 1'b1;
                ctrl_d.instr_done = 1'b1;
                state_d           = ST_FETCH;
            end
            ST_I_EXEC, ST_MEM_ADDR: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = SRCB_IMM;
                ctrl_d.aluout_en = 1'b1;
                if (state_q == ST_I_EXEC) begin
                    state_d = ST_I_WB;
                end else begin
                    state_d = (bus.opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
                end
            end
            ST_I_WB: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.instr_done = 1'b1;
                state_d           = ST_FETCH;
            end
            ST_MEM_READ: begin
                ctrl_d.mem_read = 1'b1;
                ctrl_d.iord     = 1'b1;
                if (bus.mem_ready) begin
                    ctrl_d.mdr_en = 1'b1;
                    state_d       = ST_MEM_WB;
                end else if (expired) begin
                    ctrl_d.mem_err = 1'b1;
                    state_d        = ST_FETCH;
                end
            end
            ST_MEM_WB: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
                ctrl_d.instr_done = 1'b1;
                state_d           = ST_FETCH;
            end
            ST_MEM_WRITE: begin
                ctrl_d.iord = 1'b1;
                // The write strobe drops on the abort cycle.
                ctrl_d.mem_write = !expired;
                if (bus.mem_ready) begin
                    ctrl_d.instr_done = 1'b1;
                    state_d           = ST_FETCH;
                end else if (expired) begin
                    ctrl_d.mem_err = 1'b1;
                    state_d        = ST_FETCH;
                end
            end
            ST_BRANCH: begin
                ctrl_d.alu_src_a  = 1'b1;
                ctrl_d.alu_op     = ALU_SUB;
                ctrl_d.pc_source  = PCSRC_ALUOUT;
                ctrl_d.pc_en      = bus.zero;
                ctrl_d.instr_done = 1'b1;
                state_d           = ST_FETCH;
            end
            ST_JUMP: begin
                ctrl_d.pc_source  = PCSRC_JUMP;
                ctrl_d.pc_en      = 1'b1;
                ctrl_d.instr_done = 1'b1;
                state_d           = ST_FETCH;
            end
            ST_ILLEGAL: begin
                // PC already advanced in FETCH, so the bad word is skipped.
                ctrl_d.illegal    = 1'b1;
                ctrl_d.instr_done = 1'b1;
                state_d           = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Reset gates the outputs combinationally so nothing strobes while rst is low.
    assign ctrl_out = rst ? ctrl_d : '0;

    assign bus.pc_en      = ctrl_out.pc_en;
    assign bus.ir_en      = ctrl_out.ir_en;
    assign bus.mdr_en     = ctrl_out.mdr_en;
    assign bus.ab_en      = ctrl_out.ab_en;
    assign bus.aluout_en  = ctrl_out.aluout_en;
    assign bus.reg_write  = ctrl_out.reg_write;
    assign bus.mem_read   = ctrl_out.mem_read;
    assign bus.mem_write  = ctrl_out.mem_write;
    assign bus.iord       = ctrl_out.iord;
    assign bus.reg_dst    = ctrl_out.reg_dst;
    assign bus.mem_to_reg = ctrl_out.mem_to_reg;
    assign bus.alu_src_a  = ctrl_out.alu_src_a;
    assign bus.alu_src_b  = ctrl_out.alu_src_b;
    assign bus.alu_op     = ctrl_out.alu_op;
    assign bus.pc_source  = ctrl_out.pc_source;
    assign bus.instr_done = ctrl_out.instr_done;
    assign bus.illegal    = ctrl_out.illegal;
    assign bus.mem_err    = ctrl_out.mem_err;
    assign bus.state      = rst ? state_q : ST_FETCH;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_mc_ctrl
// Directed bench for mips_mc_ctrl (MEM_WAIT_MAX = 3). Inputs change 1 ns after
// the rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mips_mc_ctrl;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst;

    mips_mc_ctrl_if bus ();

    mips_mc_ctrl #(.MEM_WAIT_MAX(3)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_done, n_pcen, n_mdr, n_regw, n_memw, n_err;
    bit pending;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({bus.pc_en, bus.ir_en, bus.mdr_en, bus.ab_en, bus.aluout_en,
                    bus.reg_write, bus.mem_read, bus.mem_write, bus.iord, bus.reg_dst,
                    bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                    bus.pc_source, bus.instr_done, bus.illegal, bus.mem_err, bus.state});
    endfunction

    task automatic clr_cnt();
        n_done = 0; n_pcen = 0; n_mdr = 0; n_regw = 0; n_memw = 0; n_err = 0;
    endtask

    // One clock cycle: advance (unless this is the first cycle after reset),
    // drive mem_ready, sample at the falling edge, check state, tally pulses.
    task automatic step(input string tag, input logic ready, input logic [3:0] exp_st);
        if (pending) begin
            @(posedge clk);
            #1;
        end
        pending = 1'b1;
        bus.mem_ready = ready;
        @(negedge clk);
        check({tag, ".state"}, 32'(bus.state), 32'(exp_st));
        if (bus.mem_read && bus.mem_write) check({tag, ".rd_wr_excl"}, 32'd1, 32'd0);
        if (bus.instr_done && bus.mem_err) check({tag, ".done_err_excl"}, 32'd1, 32'd0);
        n_done += int'(bus.instr_done);
        n_pcen += int'(bus.pc_en);
        n_mdr  += int'(bus.mdr_en);
        n_regw += int'(bus.reg_write);
        n_memw += int'(bus.mem_write);
        n_err  += int'(bus.mem_err);
    endtask

    initial begin
        rst = 1'b0;
        pending = 1'b0;
        bus.opcode = OP_RTYPE;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b1;
        #2;
        check("rst.outs", outs(), 32'd0);
        #20;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // R-type, no wait states: 4 cycles
        clr_cnt();
        bus.opcode = OP_RTYPE;
        step("r1", 1'b1, ST_FETCH);
        check("r1.ir_en", 32'(bus.ir_en), 32'd1);
        check("r1.mem_read", 32'(bus.mem_read), 32'd1);
        check("r1.srcb", 32'(bus.alu_src_b), 32'd1);
        step("r2", 1'b1, ST_DECODE);
        check("r2.ab_en", 32'(bus.ab_en), 32'd1);
        check("r2.srcb", 32'(bus.alu_src_b), 32'd3);
        step("r3", 1'b1, ST_R_EXEC);
        check("r3.alu_op", 32'(bus.alu_op), 32'd2);
        check("r3.src_a", 32'(bus.alu_src_a), 32'd1);
        step("r4", 1'b1, ST_R_WB);
        check("r4.reg_write", 32'(bus.reg_write), 32'd1);
        check("r4.reg_dst", 32'(bus.reg_dst), 32'd1);
        check("r.n_done", n_done, 32'd1);
        check("r.n_pcen", n_pcen, 32'd1);

        // lw with two wait cycles in MEM_READ: 7 cycles
        clr_cnt();
        bus.opcode = OP_LW;
        step("lw1", 1'b1, ST_FETCH);
        step("lw2", 1'b1, ST_DECODE);
        step("lw3", 1'b1, ST_MEM_ADDR);
        check("lw3.srcb", 32'(bus.alu_src_b), 32'd2);
        check("lw3.aluout_en", 32'(bus.aluout_en), 32'd1);
        step("lw4", 1'b0, ST_MEM_READ);
        check("lw4.iord", 32'(bus.iord), 32'd1);
        check("lw4.mdr_en", 32'(bus.mdr_en), 32'd0);
        step("lw5", 1'b0, ST_MEM_READ);
        check("lw5.mdr_en", 32'(bus.mdr_en), 32'd0);
        step("lw6", 1'b1, ST_MEM_READ);
        check("lw6.mdr_en", 32'(bus.mdr_en), 32'd1);
        step("lw7", 1'b1, ST_MEM_WB);
        check("lw7.mem_to_reg", 32'(bus.mem_to_reg), 32'd1);
        check("lw7.reg_write", 32'(bus.reg_write), 32'd1);
        check("lw.n_mdr", n_mdr, 32'd1);
        check("lw.n_done", n_done, 32'd1);
        check("lw.n_err", n_err, 32'd0);

        // beq taken then not taken: 3 cycles each
        for (int k = 0; k < 2; k++) begin
            clr_cnt();
            bus.opcode = OP_BEQ;
            bus.zero = (k == 0);
            step($sformatf("beq%0d.c1", k), 1'b1, ST_FETCH);
            step($sformatf("beq%0d.c2", k), 1'b1, ST_DECODE);
            step($sformatf("beq%0d.c3", k), 1'b1, ST_BRANCH);
            check($sformatf("beq%0d.pc_en", k), 32'(bus.pc_en), (k == 0) ? 32'd1 : 32'd0);
            check($sformatf("beq%0d.pc_src", k), 32'(bus.pc_source), 32'd1);
            check($sformatf("beq%0d.alu_op", k), 32'(bus.alu_op), 32'd1);
            check($sformatf("beq%0d.n_done", k), n_done, 32'd1);
        end
        bus.zero = 1'b0;

        // j: 3 cycles
        clr_cnt();
        bus.opcode = OP_J;
        step("j1", 1'b1, ST_FETCH);
        step("j2", 1'b1, ST_DECODE);
        step("j3", 1'b1, ST_JUMP);
        check("j3.pc_en", 32'(bus.pc_en), 32'd1);
        check("j3.pc_src", 32'(bus.pc_source), 32'd2);
        check("j.n_done", n_done, 32'd1);

        // addi: 4 cycles
        clr_cnt();
        bus.opcode = OP_ADDI;
        step("ad1", 1'b1, ST_FETCH);
        step("ad2", 1'b1, ST_DECODE);
        step("ad3", 1'b1, ST_I_EXEC);
        check("ad3.srcb", 32'(bus.alu_src_b), 32'd2);
        step("ad4", 1'b1, ST_I_WB);
        check("ad4.reg_write", 32'(bus.reg_write), 32'd1);
        check("ad4.reg_dst", 32'(bus.reg_dst), 32'd0);

        // unsupported opcode
        clr_cnt();
        bus.opcode = 6'h3F;
        step("il1", 1'b1, ST_FETCH);
        step("il2", 1'b1, ST_DECODE);
        step("il3", 1'b1, ST_ILLEGAL);
        check("il3.illegal", 32'(bus.illegal), 32'd1);
        check("il3.done", 32'(bus.instr_done), 32'd1);
        check("il.n_regw", n_regw, 32'd0);
        check("il.n_memw", n_memw, 32'd0);

        // sw with mem_ready stuck low: abort on 4th MEM_WRITE cycle
        clr_cnt();
        bus.opcode = OP_SW;
        step("swt.c1", 1'b1, ST_FETCH);
        step("swt.c2", 1'b1, ST_DECODE);
        step("swt.c3", 1'b1, ST_MEM_ADDR);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("swt.w%0d", i), 1'b0, ST_MEM_WRITE);
            check($sformatf("swt.w%0d.mem_write", i), 32'(bus.mem_write), 32'd1);
            check($sformatf("swt.w%0d.mem_err", i), 32'(bus.mem_err), 32'd0);
        end
        step("swt.w3", 1'b0, ST_MEM_WRITE);
        check("swt.w3.mem_err", 32'(bus.mem_err), 32'd1);
        check("swt.w3.mem_write", 32'(bus.mem_write), 32'd0);
        check("swt.n_done", n_done, 32'd0);

        // sw with mem_ready rising exactly on the limit cycle
        clr_cnt();
        step("swk.c1", 1'b1, ST_FETCH);
        step("swk.c2", 1'b1, ST_DECODE);
        step("swk.c3", 1'b1, ST_MEM_ADDR);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("swk.w%0d", i), 1'b0, ST_MEM_WRITE);
        end
        step("swk.w3", 1'b1, ST_MEM_WRITE);
        check("swk.w3.done", 32'(bus.instr_done), 32'd1);
        check("swk.w3.mem_err", 32'(bus.mem_err), 32'd0);
        check("swk.n_err", n_err, 32'd0);
        step("swk.next", 1'b1, ST_FETCH);

        // reset in the middle of a MEM_READ wait
        bus.opcode = OP_LW;
        step("rr.c2", 1'b1, ST_DECODE);
        step("rr.c3", 1'b1, ST_MEM_ADDR);
        step("rr.w0", 1'b0, ST_MEM_READ);
        step("rr.w1", 1'b0, ST_MEM_READ);
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        #1;
        check("rr.pre_rst.mem_read", 32'(bus.mem_read), 32'd1);
        rst = 1'b0;
        #1;
        check("rr.rst.outs", outs(), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        pending = 1'b0;
        // A cleared counter needs three full wait cycles before the abort.
        clr_cnt();
        for (int i = 0; i < 3; i++) begin
            step($sformatf("rf.w%0d", i), 1'b0, ST_FETCH);
            check($sformatf("rf.w%0d.mem_err", i), 32'(bus.mem_err), 32'd0);
            check($sformatf("rf.w%0d.pc_en", i), 32'(bus.pc_en), 32'd0);
        end
        step("rf.w3", 1'b0, ST_FETCH);
        check("rf.w3.mem_err", 32'(bus.mem_err), 32'd1);
        step("rf.go", 1'b1, ST_FETCH);
        check("rf.go.pc_en", 32'(bus.pc_en), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
